csr_bank: RTL and testbench
===========================

# csr_bank

Parametrised control/status register bank: N_REGS registers of DATA_W bits, each with its own reset value and access mode. It adds byte-strobed writes, per-register RO/W1C/pulse modes, hardware event inputs and a registered read port with a valid strobe. It sits between the HPS bridge slave decode and fabric datapaths, and replaces hand-instantiated single 32-bit registers.

## Interface
- DATA_W, 32: register width; multiple of 8.
- N_REGS, 8: number of registers; ≥1.
- ADDR_W, $clog2(N_REGS) (min 1): word-address width.
- RST_VAL, all 0: packed [N_REGS-1:0][DATA_W-1:0]; per-register reset value.
- MODE, all CSR_RW: packed [N_REGS-1:0] of csr_mode_e; per-register access mode.

Ports:
- i_clk  in  1  clock.
- i_arstn  in  1  reset, asynchronous assert, active-low.
- i_wr  in  1  write strobe, single cycle.
- i_waddr  in  ADDR_W  write word address.
- i_wdata  in  DATA_W  write data.
- i_wstrb  in  DATA_W/8  byte enables.
- i_rd  in  1  read strobe.
- i_raddr  in  ADDR_W  read word address.
- o_rdata  out  DATA_W  read data; valid with o_rvalid.
- o_rvalid  out  1  read response strobe.
- o_rerr  out  1  out-of-range read; qualified by o_rvalid.
- i_hw_val  in  N_REGS*DATA_W  live value for CSR_RO registers.
- i_hw_set  in  N_REGS*DATA_W  per-bit event set for CSR_W1C registers.
- o_regs  out  N_REGS*DATA_W  current contents of all registers, to fabric.

## Operation
- Modes:
  - CSR_RW: strobed bytes are written from i_wdata.
  - CSR_RO: storage loads i_hw_val[i] every cycle. Writes are ignored.
  - CSR_W1C: bit is set when its i_hw_set bit is 1. A write with a 1 in a strobed byte clears that bit. A same-cycle set and clear of one bit leaves it set.
  - CSR_PULSE: a write drives o_regs[i] = strobed i_wdata bits for exactly one cycle, then 0. Reads return 0.
- Byte strobes:
  - Bytes with i_wstrb=0 are untouched in every mode.
  - i_wstrb=0 with i_wr=1 is a no-op.
- Addresses ≥ N_REGS:
  - Writes are ignored.
  - Reads return o_rdata=0 and o_rerr=1.
- i_hw_set bits for non-W1C registers, and i_hw_val for non-RO registers, are ignored.
- On reset:
  - Every register takes RST_VAL[i], except CSR_PULSE, which resets to 0.
  - o_rdata=0, o_rvalid=0, o_rerr=0.

## Timing
- Write:
  - Commits on the i_clk edge where i_wr=1.
  - o_regs reflects the new value the cycle after the edge.
- Read:
  - Latency is 1 cycle. o_rvalid is high the cycle after i_rd is sampled.
  - o_rdata and o_rerr are registered and hold until the next read.
  - Back-to-back reads every cycle are supported, one response per cycle.
- Same-cycle read and write to the same address: the read returns the pre-write value.
- CSR_RO: o_regs lags i_hw_val by 1 cycle, and a read returns the value sampled at the i_rd edge.
- W1C events: a set asserted at edge k is visible on o_regs after edge k. Single-cycle events are never lost.
- Reset asserted mid-operation: a pending o_rvalid and any active pulse are dropped immediately, asynchronously.
- There is no backpressure. i_wr and i_rd are accepted every cycle.

## Structure
- Package csr_bank_pkg holds:
  - typedef enum logic [1:0] csr_mode_e {CSR_RW, CSR_RO, CSR_W1C, CSR_PULSE};
  - helper function for the strobe-expanded bit mask.
- Sub-module csr_reg_cell:
  - One register with mode parameter, reset value, strobed write, hw_set and hw_val.
  - Instantiated N_REGS times by generate.
- The read mux and response registers live in csr_bank.

## Test plan
- Reset: RST_VAL[2]=32'hDEAD_BEEF, MODE[2]=RW -> o_regs[2]=32'hDEAD_BEEF; o_rvalid=0; pulse outputs 0.
- Strobed write: RW reg 0 holding 32'h1122_3344, write 32'hAABB_CCDD with strb 4'b0101 -> reg 0 = 32'h11BB_33DD; a read one cycle later returns it with o_rvalid=1.
- W1C:
  - Pulse i_hw_set[3]=32'h0000_0009 -> reg 3 = 9.
  - Write 32'h1 -> reg 3 = 8.
  - In the same cycle, set bit 0 and write-clear bit 0 -> bit 0 stays 1.
- PULSE and RO:
  - Write 32'h5 to PULSE reg 4 -> o_regs[4]=5 for one cycle, then 0; a read returns 0.
  - RO reg 5 with i_hw_val=32'h77 -> reads 32'h77; a write of 32'h0 has no effect.
- Read/write collision and out of range:
  - Same-cycle read and write of reg 1 (old 32'h1, new 32'h2) -> read returns 32'h1.
  - Read address N_REGS -> o_rdata=0, o_rerr=1.
  - Write address N_REGS -> all registers unchanged.
- Mid-read reset: assert i_arstn low between i_rd and its response -> o_rvalid is 0 immediately, and all registers are back at reset values.

Source files
------------

// File: rtl/csr_bank_pkg.sv
// Shared types and helpers for the CSR register bank.
// Holds the per-register access mode enum and the byte-lane mask helper.
// No logic of its own; imported by csr_reg_cell and csr_bank.
package csr_bank_pkg;

    typedef enum logic [1:0] {
        CSR_RW    = 2'd0,
        CSR_RO    = 2'd1,
        CSR_W1C   = 2'd2,
        CSR_PULSE = 2'd3
    } csr_mode_e;

    // One byte lane of the write mask: all ones only when the write is
    // active and that lane's strobe is set.
    function automatic logic [7:0] lane_mask(input logic wr, input logic strb);
        return {8{wr & strb}};
    endfunction

endpackage

// File: rtl/csr_reg_cell.sv
// Single CSR register with a compile-time access mode (RW / RO / W1C / PULSE).
// Latency: writes, hw_set events and hw_val samples appear on q one cycle later.
// Backpressure: none; a write or event is absorbed every cycle.
//
// Ports: clk, arstn (async active-low), wr (write select for this register),
//        wdata/wstrb (write data and byte enables), hw_set (W1C event bits),
//        hw_val (live value for RO), q (register contents).
module csr_reg_cell
    import csr_bank_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter csr_mode_e         MODE    = CSR_RW,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  wr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     hw_set,
    input  logic [DATA_W-1:0]     hw_val,
    output logic [DATA_W-1:0]     q
);

    // Pulse registers always come out of reset idle, whatever RST_VAL says.
    localparam logic [DATA_W-1:0] RESET_Q = (MODE == CSR_PULSE) ? '0 : RST_VAL;

    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] wbits;
    logic [DATA_W-1:0] q_nxt;

    for (genvar b = 0; b < DATA_W/8; b++) begin : g_lane
        assign wmask[8*b +: 8] = lane_mask(wr, wstrb[b]);
    end

    assign wbits = wdata & wmask;

    always_comb begin
        q_nxt = q;
        case (MODE)
            CSR_RW:    q_nxt = (q & ~wmask) | wbits;
            CSR_RO:    q_nxt = hw_val;
            // OR-ing the set after the clear makes a same-cycle set win.
            CSR_W1C:   q_nxt = (q & ~wbits) | hw_set;
            CSR_PULSE: q_nxt = wbits;
            default:   q_nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            q <= RESET_Q;
        end else begin
            q <= q_nxt;
        end
    end

    // Each mode ignores some inputs; fold them together so the
    // specialisations that drop them do not leave dangling ports.
    logic unused_inputs;
    assign unused_inputs = ^{wr, wdata, wstrb, hw_set, hw_val};

endmodule

// File: rtl/csr_bank.sv
// Parametrised control/status register bank with byte-strobed writes and a registered read port.
// Latency: writes visible on o_regs one cycle after the edge; read response one cycle after i_rd.
// Backpressure: none; i_wr and i_rd are accepted every cycle.
//
// Ports: i_clk, i_arstn (async active-low); write port i_wr/i_waddr/i_wdata/i_wstrb;
//        read port i_rd/i_raddr -> o_rdata/o_rvalid/o_rerr; hardware side i_hw_val (RO),
//        i_hw_set (W1C events); o_regs carries all register contents to the fabric.
module csr_bank
    import csr_bank_pkg::*;
#(
    parameter int                               DATA_W  = 32,
    parameter int                               N_REGS  = 8,
    parameter int                               ADDR_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    parameter logic [N_REGS-1:0][DATA_W-1:0]    RST_VAL = '0,
    parameter csr_mode_e [N_REGS-1:0]           MODE    = '{default: CSR_RW}
) (
    input  logic                        i_clk,
    input  logic                        i_arstn,
    input  logic                        i_wr,
    input  logic [ADDR_W-1:0]           i_waddr,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [DATA_W/8-1:0]         i_wstrb,
    input  logic                        i_rd,
    input  logic [ADDR_W-1:0]           i_raddr,
    output logic [DATA_W-1:0]           o_rdata,
    output logic                        o_rvalid,
    output logic                        o_rerr,
    input  logic [N_REGS*DATA_W-1:0]    i_hw_val,
    input  logic [N_REGS*DATA_W-1:0]    i_hw_set,
    output logic [N_REGS*DATA_W-1:0]    o_regs
);

    logic [N_REGS-1:0][DATA_W-1:0] regs;

    // Out-of-range write addresses match no cell, so they fall away here.
    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        logic sel;
        assign sel = i_wr && (i_waddr == ADDR_W'(i));

        csr_reg_cell #(
            .DATA_W  (DATA_W),
            .MODE    (MODE[i]),
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk    (i_clk),
            .arstn  (i_arstn),
            .wr     (sel),
            .wdata  (i_wdata),
            .wstrb  (i_wstrb),
            .hw_set (i_hw_set[i*DATA_W +: DATA_W]),
            .hw_val (i_hw_val[i*DATA_W +: DATA_W]),
            .q      (regs[i])
        );
    end

    assign o_regs = regs;

    // Read mux. Register contents are taken before any same-cycle write lands,
    // so a colliding read returns the old value. RO registers return the live
    // hardware value present at the read edge rather than the one-cycle-old copy.
    logic [DATA_W-1:0] rd_val;
    logic              rd_hit;

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (i_raddr == ADDR_W'(i)) begin
                rd_hit = 1'b1;
                case (MODE[i])
                    CSR_PULSE: rd_val = '0;
                    CSR_RO:    rd_val = i_hw_val[i*DATA_W +: DATA_W];
                    default:   rd_val = regs[i];
                endcase
            end
        end
    end

    // Response registers: rdata/rerr hold until the next read.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
            o_rerr   <= 1'b0;
        end else begin
            o_rvalid <= i_rd;
            if (i_rd) begin
                o_rdata <= rd_val;
                o_rerr  <= ~rd_hit;
            end
        end
    end

endmodule

// File: tb/tb_csr_bank.sv
module tb_csr_bank;
    import csr_bank_pkg::*;

    localparam int DW = 32;
    localparam int NR = 6;
    localparam int AW = 3;

    localparam logic [NR-1:0][DW-1:0] TB_RST =
        {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0000_0001, 32'h1122_3344};
    localparam csr_mode_e [NR-1:0] TB_MODE =
        '{CSR_RO, CSR_PULSE, CSR_W1C, CSR_RW, CSR_RW, CSR_RW};

    logic                   clk = 1'b0;
    logic                   arstn;
    logic                   wr;
    logic [AW-1:0]          waddr;
    logic [DW-1:0]          wdata;
    logic [DW/8-1:0]        wstrb;
    logic                   rd;
    logic [AW-1:0]          raddr;
    logic [DW-1:0]          rdata;
    logic                   rvalid;
    logic                   rerr;
    logic [NR-1:0][DW-1:0]  hw_val;
    logic [NR-1:0][DW-1:0]  hw_set;
    logic [NR-1:0][DW-1:0]  regs;

    csr_bank #(
        .DATA_W  (DW),
        .N_REGS  (NR),
        .ADDR_W  (AW),
        .RST_VAL (TB_RST),
        .MODE    (TB_MODE)
    ) dut (
        .i_clk    (clk),
        .i_arstn  (arstn),
        .i_wr     (wr),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_wstrb  (wstrb),
        .i_rd     (rd),
        .i_raddr  (raddr),
        .o_rdata  (rdata),
        .o_rvalid (rvalid),
        .o_rerr   (rerr),
        .i_hw_val (hw_val),
        .i_hw_set (hw_set),
        .o_regs   (regs)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        logic          rd;
        logic [AW-1:0] raddr;
        logic [DW-1:0] set3;
        int            ridx;
        logic [DW-1:0] ereg;
        logic          erv;
        logic [DW-1:0] erd;
        logic          ere;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [3:0] ws, input logic r, input logic [AW-1:0] ra,
                                input logic [DW-1:0] s3, input int ri, input logic [DW-1:0] er,
                                input logic erv, input logic [DW-1:0] erd, input logic ere);
        vec_t v;
        v.wr = w;   v.waddr = wa; v.wdata = wd; v.wstrb = ws;
        v.rd = r;   v.raddr = ra; v.set3 = s3;
        v.ridx = ri; v.ereg = er; v.erv = erv; v.erd = erd; v.ere = ere;
        return v;
    endfunction

    task automatic idle_inputs();
        wr = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
        rd = 1'b0; raddr = '0; hw_set = '0;
    endtask

    logic [NR-1:0][DW-1:0] exp_all;

    initial begin
        //      wr wa  wdata          strb     rd ra  set3   idx ereg           rv rdata          rerr
        tbl.push_back(mk(1, 0, 32'hAABB_CCDD, 4'b0101, 0, 0, 32'h0, 0, 32'h11BB_33DD, 0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 0, 32'h0, 0, 32'h11BB_33DD, 1, 32'h11BB_33DD, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0, 32'h9, 3, 32'h9,         0, 32'h11BB_33DD, 0));
        tbl.push_back(mk(1, 3, 32'h1,         4'b1111, 0, 0, 32'h0, 3, 32'h8,         0, 32'h11BB_33DD, 0));
        tbl.push_back(mk(1, 3, 32'h1,         4'b1111, 0, 0, 32'h1, 3, 32'h9,         0, 32'h11BB_33DD, 0));
        tbl.push_back(mk(1, 3, 32'h8,         4'b0000, 0, 0, 32'h0, 3, 32'h9,         0, 32'h11BB_33DD, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 3, 32'h0, 3, 32'h9,         1, 32'h9,         0));
        tbl.push_back(mk(1, 4, 32'h5,         4'b1111, 0, 0, 32'h0, 4, 32'h5,         0, 32'h9,         0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 0, 0, 32'h0, 4, 32'h0,         0, 32'h9,         0));
        tbl.push_back(mk(1, 4, 32'h5,         4'b1111, 1, 4, 32'h0, 4, 32'h5,         1, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 5, 32'h0, 5, 32'h77,        1, 32'h77,        0));
        tbl.push_back(mk(1, 5, 32'h0,         4'b1111, 0, 0, 32'h0, 5, 32'h77,        0, 32'h77,        0));
        tbl.push_back(mk(1, 1, 32'h2,         4'b1111, 1, 1, 32'h0, 1, 32'h2,         1, 32'h1,         0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 1, 32'h0, 1, 32'h2,         1, 32'h2,         0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 6, 32'h0, 1, 32'h2,         1, 32'h0,         1));
        tbl.push_back(mk(1, 6, 32'hFFFF_FFFF, 4'b1111, 0, 0, 32'h0, 0, 32'h11BB_33DD, 0, 32'h0,         1));
        tbl.push_back(mk(1, 7, 32'hFFFF_FFFF, 4'b1111, 1, 2, 32'h0, 2, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 7, 32'h0, 3, 32'h9,         1, 32'h0,         1));
        tbl.push_back(mk(1, 0, 32'h0,         4'b1000, 0, 0, 32'h0, 0, 32'h00BB_33DD, 0, 32'h0,         1));
        tbl.push_back(mk(1, 3, 32'hFFFF_FFFF, 4'b1110, 0, 0, 32'h0, 3, 32'h9,         0, 32'h0,         1));
        tbl.push_back(mk(0, 0, 32'h0,         4'b0000, 1, 4, 32'h0, 4, 32'h0,         1, 32'h0,         0));

        idle_inputs();
        hw_val    = '0;
        hw_val[5] = 32'h77;
        arstn     = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, sampled while reset is held.
        chk("rst reg0",   regs[0], 32'h1122_3344);
        chk("rst reg1",   regs[1], 32'h1);
        chk("rst reg2",   regs[2], 32'hDEAD_BEEF);
        chk("rst pulse4", regs[4], 32'h0);
        chk("rst rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst rdata",  rdata, 32'h0);
        chk("rst rerr",   {31'b0, rerr}, 32'h0);
        arstn = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            wr = tbl[k].wr; waddr = tbl[k].waddr; wdata = tbl[k].wdata; wstrb = tbl[k].wstrb;
            rd = tbl[k].rd; raddr = tbl[k].raddr;
            hw_set    = '0;
            hw_set[3] = tbl[k].set3;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d reg%0d", k, tbl[k].ridx), regs[tbl[k].ridx], tbl[k].ereg);
            chk($sformatf("v%0d rvalid", k), {31'b0, rvalid}, {31'b0, tbl[k].erv});
            chk($sformatf("v%0d rdata", k), rdata, tbl[k].erd);
            chk($sformatf("v%0d rerr", k), {31'b0, rerr}, {31'b0, tbl[k].ere});
            idle_inputs();
        end

        // Whole bank after the sequence, including the out-of-range writes.
        exp_all = {32'h77, 32'h0, 32'h9, 32'hDEAD_BEEF, 32'h2, 32'h00BB_33DD};
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("final reg%0d", i), regs[i], exp_all[i]);
        end

        // Reset arriving between a read and its response, with a pulse live.
        wr = 1'b1; waddr = 3'd4; wdata = 32'h5; wstrb = 4'b1111;
        rd = 1'b1; raddr = 3'd2;
        @(posedge clk);
        #2;
        chk("pre-rst rvalid", {31'b0, rvalid}, 32'h1);
        chk("pre-rst pulse4", regs[4], 32'h5);
        arstn = 1'b0;
        #1;
        chk("midrst rvalid", {31'b0, rvalid}, 32'h0);
        chk("midrst rdata",  rdata, 32'h0);
        chk("midrst pulse4", regs[4], 32'h0);
        exp_all = {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h1, 32'h1122_3344};
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("midrst reg%0d", i), regs[i], exp_all[i]);
        end
        idle_inputs();
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post-rst ro5", regs[5], 32'h77);
        chk("post-rst rvalid", {31'b0, rvalid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
